// File: rtl/muldiv_seq_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states
// and small decode helpers used by the top level.
package muldiv_seq_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV    = 2'b10,
    OP_REM    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // MUL_HI and REM both come out of the accumulator; MUL_LO and DIV out of the shift register.
  function automatic logic op_takes_acc(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a right-shifting shift-add multiply step
// or a left-shifting restoring-division step, selected by is_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sreg_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // NOTE: every output of a combinational block is given a value on every path, so no latch is inferred.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, opnd};
    addend    = {1'b0, acc};
    shifted   = {acc, sreg[WIDTH-1]};
    fits      = (shifted >= {1'b0, opnd});
    // When the divisor fits, the true difference is below the divisor, so WIDTH bits suffice.
    diff      = shifted[WIDTH-1:0] - opnd;
    acc_next  = acc;
    sreg_next = sreg;

    if (is_div) begin
      acc_next  = fits ? diff : shifted[WIDTH-1:0];
      sreg_next = {sreg[WIDTH-2:0], fits};
    end else begin
      if (sreg[0]) begin
        addend = sum;
      end
      acc_next  = addend[WIDTH:1];
      sreg_next = {addend[0], sreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative unsigned multiply/divide unit, one bit per clock. Feeds the MULDIV
// slot of the result mux; busy stalls the PC, done marks a fresh result.
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state;
  state_e           state_next;
  op_e              op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    count;
  logic             last_iter;

  assign last_iter = (count == CW'(1));
  assign result    = result_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_iter) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .sreg     (sreg),
    .opnd     (opnd),
    .acc_next (acc_next),
    .sreg_next(sreg_next)
  );

  // NOTE: the datapath registers are cleared on reset too, so an aborted operation leaves no stale result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OP_MUL_LO;
      opnd     <= '0;
      acc      <= '0;
      sreg     <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            // Division shifts the dividend out of sreg; multiply shifts the multiplier out.
            opnd  <= op[1] ? b : a;
            sreg  <= op[1] ? a : b;
            acc   <= '0;
            count <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          sreg  <= sreg_next;
          count <= count - CW'(1);
          if (last_iter) begin
            result_q <= op_takes_acc(op_q) ? acc_next : sreg_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed cases, in-run start pulses,
// mid-run reset, randomized ops and a back-to-back stream against an arithmetic model.
module tb_muldiv_seq_unit;

  localparam int W      = 32;
  localparam int LAT    = 33;
  localparam int PERIOD = 34;
  localparam int NB2B   = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held   = '0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == 0) ? '1 : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    op = 2'($urandom_range(3));
    a  = $urandom;
    b  = $urandom;
  endtask

  // Issue one op and follow it to completion; p1/p2 are RUN cycles at which start is pulsed again.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int p1, input int p2);
    logic [W-1:0] exp;
    int cyc, busy_cnt;
    bit got;
    exp = ref_model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    cyc = 0; busy_cnt = 0; got = 0;
    while (cyc < LAT + 6 && !got) begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1) || (cyc == p2);
      scramble();
      if (done) begin
        got = 1;
      end else begin
        check({tag, " stable"}, result, held);
        if (busy) busy_cnt++;
      end
    end
    check({tag, " latency"}, W'(cyc), W'(LAT));
    check({tag, " busy_cycles"}, W'(busy_cnt), W'(32));
    check({tag, " busy_at_done"}, W'(busy), W'(0));
    check({tag, " result"}, result, exp);
    held = exp;
    start = 1'b0;
    @(negedge clk);
    check({tag, " done_pulse_width"}, W'(done), W'(0));
    check({tag, " result_hold"}, result, held);
  endtask

  initial begin
    logic [1:0]   bo [NB2B*PERIOD];
    logic [W-1:0] ba [NB2B*PERIOD];
    logic [W-1:0] bb [NB2B*PERIOD];
    logic [W-1:0] y;
    int dones;

    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset result", result, '0);
    rst = 1'b1;

    run_op("mul_lo_7x6", 2'd0, 32'd7, 32'd6, 0, 0);
    run_op("mul_hi_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("mul_lo_ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div_100_7", 2'd2, 32'd100, 32'd7, 0, 0);
    run_op("rem_100_7", 2'd3, 32'd100, 32'd7, 0, 0);
    run_op("div_by_zero", 2'd2, 32'd5, 32'd0, 0, 0);
    run_op("rem_by_zero", 2'd3, 32'd5, 32'd0, 0, 0);
    run_op("start_ignored", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, 32);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("start_ignored extra_done", W'(dones), W'(0));

    // Abort an operation at RUN cycle 10 with a non-zero result already held.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd11; b = 32'd13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort result", result, '0);
    rst = 1'b1;
    held = '0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", W'(dones), W'(0));
    run_op("after_abort_3x3", 2'd0, 32'd3, 32'd3, 0, 0);

    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       y = '0;
        1:       y = W'($urandom_range(1, 255));
        default: y = $urandom;
      endcase
      run_op("random", 2'($urandom_range(3)), $urandom, y, (i % 3 == 0) ? int'($urandom_range(1, 32)) : 0, 0);
    end

    // Start held high: accepts land every PERIOD edges, starting at the first edge.
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < NB2B * PERIOD; n++) begin
      scramble();
      if (n % 5 == 0) b = '0;
      bo[n] = op; ba[n] = a; bb[n] = b;
      @(negedge clk);
      check("b2b done", W'(done), W'(n % PERIOD == PERIOD - 2));
      if (n % PERIOD == PERIOD - 2) begin
        check("b2b result", result,
              ref_model(bo[n - (PERIOD - 2)], ba[n - (PERIOD - 2)], bb[n - (PERIOD - 2)]));
      end
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
